ifetch_prefetch_queue: RTL

- Instruction-fetch front end directly upstream of the single-cycle RV32I core.
- Issues sequential word fetches to a variable-latency instruction memory over a req/rsp handshake.
- Buffers returned instructions with their PCs in an in-order queue and presents them to the core on a valid/ready interface.
- On a core redirect (taken branch/jump), flushes the queue, discards in-flight responses and restarts fetch at the new PC.

---
 rtl/ifetch_prefetch_queue.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ifetch_prefetch_queue.sv
// ifetch_prefetch_queue
//
// Instruction-fetch front end for the single-cycle RV32I core. It issues
// sequential word fetches to a variable-latency instruction memory. It
// buffers the returned words with their PCs in an in-order queue and hands
// them to the core on a valid/ready interface. A redirect from the core
// flushes the queue and restarts fetch at the new PC. Any responses still
// in flight at that point are counted and dropped when they arrive.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   mem_req_*       fetch request (valid/ready), word address
//   mem_rsp_*       in-order fetch responses, one per accepted request
//   redirect_*      core fetch redirect (target bits [1:0] ignored)
//   inst_*          queue head presented to the core (valid/ready)
//   busy            requests in flight or stale responses still expected
module ifetch_prefetch_queue #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data,
  input  logic        inst_ready,
  output logic        busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  // MAX_OUTSTANDING <= DEPTH, so one counter width covers every counter
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];

  logic [31:0]   fetch_pc_r;
  logic [31:0]   rsp_pc_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] discard_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic          req_valid_r;

  logic          req_fire_s;
  logic          push_s;
  logic          pop_s;
  logic [31:0]   fetch_pc_nx_s;
  logic [31:0]   rsp_pc_nx_s;
  logic [CW-1:0] count_nx_s;
  logic [CW-1:0] outstanding_nx_s;
  logic [CW-1:0] discard_nx_s;
  logic [CW:0]   occupancy_nx_s;
  logic          req_valid_nx_s;
  logic          unused_s;

  // Low address bits of the redirect target are deliberately ignored
  assign unused_s = ^redirect_pc[1:0];

  // Handshake qualification; a redirect drops the response and the pop
  always_comb begin
    req_fire_s = req_valid_r & mem_req_ready;
    push_s     = mem_rsp_valid & ~redirect_valid & (discard_r == {CW{1'b0}});
    pop_s      = (count_r != {CW{1'b0}}) & inst_ready & ~redirect_valid;
  end

  // Next-state computation; a redirect overrides queue and PC updates
  always_comb begin
    count_nx_s    = count_r;
    discard_nx_s  = discard_r;
    fetch_pc_nx_s = fetch_pc_r;
    rsp_pc_nx_s   = rsp_pc_r;
    case ({req_fire_s, mem_rsp_valid})
      2'b10:   outstanding_nx_s = outstanding_r + CW'(1'b1);
      2'b01:   outstanding_nx_s = outstanding_r - CW'(1'b1);
      default: outstanding_nx_s = outstanding_r;
    endcase
    if (redirect_valid) begin
      // Everything still in flight after this edge belongs to the old stream
      count_nx_s    = {CW{1'b0}};
      discard_nx_s  = outstanding_nx_s;
      fetch_pc_nx_s = {redirect_pc[31:2], 2'b00};
      rsp_pc_nx_s   = {redirect_pc[31:2], 2'b00};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_nx_s = count_r + CW'(1'b1);
        2'b01:   count_nx_s = count_r - CW'(1'b1);
        default: count_nx_s = count_r;
      endcase
      if (mem_rsp_valid && (discard_r != {CW{1'b0}})) begin
        discard_nx_s = discard_r - CW'(1'b1);
      end else begin
        discard_nx_s = discard_r;
      end
      if (req_fire_s) begin
        fetch_pc_nx_s = fetch_pc_r + 32'd4;
      end else begin
        fetch_pc_nx_s = fetch_pc_r;
      end
      // Kept responses arrive in request order, so their PCs are sequential
      // from the last redirect target
      if (push_s) begin
        rsp_pc_nx_s = rsp_pc_r + 32'd4;
      end else begin
        rsp_pc_nx_s = rsp_pc_r;
      end
    end
    // Reserve queue space for every request in flight so a response always fits
    occupancy_nx_s = {1'b0, count_nx_s} + {1'b0, outstanding_nx_s};
    req_valid_nx_s = (occupancy_nx_s < (CW+1)'(DEPTH)) &&
                     (outstanding_nx_s < CW'(MAX_OUTSTANDING));
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r    <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      count_r       <= {CW{1'b0}};
      outstanding_r <= {CW{1'b0}};
      discard_r     <= {CW{1'b0}};
      rd_ptr_r      <= {PW{1'b0}};
      wr_ptr_r      <= {PW{1'b0}};
      req_valid_r   <= 1'b0;
    end else begin
      fetch_pc_r    <= fetch_pc_nx_s;
      rsp_pc_r      <= rsp_pc_nx_s;
      count_r       <= count_nx_s;
      outstanding_r <= outstanding_nx_s;
      discard_r     <= discard_nx_s;
      req_valid_r   <= req_valid_nx_s;
      if (redirect_valid) begin
        rd_ptr_r <= {PW{1'b0}};
        wr_ptr_r <= {PW{1'b0}};
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PW'(1'b1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PW'(1'b1);
        end
      end
    end
  end

  // Queue storage write port; no reset needed as inst_valid gates the head
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_q[wr_ptr_r]   <= rsp_pc_r;
      data_q[wr_ptr_r] <= mem_rsp_data;
    end
  end

  assign mem_req_valid = req_valid_r;
  assign mem_req_addr  = fetch_pc_r;
  assign inst_valid    = (count_r != {CW{1'b0}});
  assign inst_pc       = inst_valid ? pc_q[rd_ptr_r]   : 32'h0000_0000;
  assign inst_data     = inst_valid ? data_q[rd_ptr_r] : 32'h0000_0000;
  assign busy          = (outstanding_r != {CW{1'b0}}) | (discard_r != {CW{1'b0}});

endmodule
